// File: rtl/spi_txn_sequencer.sv
// Command sequencer in front of the SPI master: buffers host byte requests in a TX FIFO,
// issues them one at a time over the master's enable/busy handshake, and collects reads in an RX FIFO.
module spi_txn_sequencer #(
    parameter int DEPTH         = 8,
    parameter int START_TIMEOUT = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_push_i,
    input  logic                   tx_write_i,
    input  logic [7:0]             tx_data_i,
    output logic                   tx_full_o,
    output logic [$clog2(DEPTH):0] tx_count_o,
    input  logic                   rx_pop_i,
    output logic [7:0]             rx_data_o,
    output logic                   rx_empty_o,
    output logic [$clog2(DEPTH):0] rx_count_o,
    output logic [7:0]             spi_data_o,
    output logic                   spi_write_o,
    output logic                   spi_enable_o,
    input  logic                   spi_busy_i,
    input  logic [7:0]             spi_data_i,
    output logic                   idle_o,
    output logic [1:0]             err_o,
    input  logic                   err_clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [TW-1:0] TMO_ONE    = TW'(1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_END   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [8:0]    tx_mem_r [DEPTH];
    logic [7:0]    rx_mem_r [DEPTH];
    logic [AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CW-1:0] tx_count_r, tx_count_s, rx_count_r, rx_count_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [7:0]    spi_data_r;
    logic          spi_write_r, spi_enable_r, idle_r, tx_full_r, rx_empty_r;
    logic [1:0]    err_r, err_s;
    logic [8:0]    tx_head_s;
    logic          tx_push_ok_s, tx_ovf_s, tx_pop_s, rx_push_s, rx_pop_ok_s;
    logic          tmo_clr_s, tmo_inc_s, tmo_err_s;

    assign tx_head_s    = tx_mem_r[tx_rd_ptr_r];
    assign tx_push_ok_s = tx_push_i & ~tx_full_r;
    assign tx_ovf_s     = tx_push_i & tx_full_r;
    assign rx_pop_ok_s  = rx_pop_i & ~rx_empty_r;

    // Sequencing FSM: a read is only launched when its result is guaranteed an RX slot
    always_comb begin
        state_s   = state_r;
        tx_pop_s  = 1'b0;
        rx_push_s = 1'b0;
        tmo_clr_s = 1'b0;
        tmo_inc_s = 1'b0;
        tmo_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((tx_count_r != CNT_ZERO) && (tx_head_s[8] || (rx_count_r != FULL_COUNT))) begin
                    tx_pop_s = 1'b1;
                    state_s  = ST_ISSUE;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_clr_s = 1'b1;
                state_s   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (spi_busy_i) begin
                    state_s = ST_WAIT_END;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_err_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    tmo_inc_s = 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (!spi_busy_i) begin
                    rx_push_s = ~spi_write_r;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_WAIT_END;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next occupancy of both FIFOs
    always_comb begin
        tx_count_s = tx_count_r;
        rx_count_s = rx_count_r;
        case ({tx_push_ok_s, tx_pop_s})
            2'b10:   tx_count_s = tx_count_r + CNT_ONE;
            2'b01:   tx_count_s = tx_count_r - CNT_ONE;
            default: tx_count_s = tx_count_r;
        endcase
        case ({rx_push_s, rx_pop_ok_s})
            2'b10:   rx_count_s = rx_count_r + CNT_ONE;
            2'b01:   rx_count_s = rx_count_r - CNT_ONE;
            default: rx_count_s = rx_count_r;
        endcase
        err_s = {(err_r[1] & ~err_clr_i) | tmo_err_s, (err_r[0] & ~err_clr_i) | tx_ovf_s};
    end

    // FIFO storage; occupancy gates every read so contents need no reset
    always_ff @(posedge clk_i) begin
        if (tx_push_ok_s) tx_mem_r[tx_wr_ptr_r] <= {tx_write_i, tx_data_i};
        if (rx_push_s)    rx_mem_r[rx_wr_ptr_r] <= spi_data_i;
    end

    // Pointers, counts, FSM state and timeout counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wr_ptr_r <= {AW{1'b0}};
            tx_rd_ptr_r <= {AW{1'b0}};
            rx_wr_ptr_r <= {AW{1'b0}};
            rx_rd_ptr_r <= {AW{1'b0}};
            tx_count_r  <= CNT_ZERO;
            rx_count_r  <= CNT_ZERO;
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= {TW{1'b0}};
        end else begin
            if (tx_push_ok_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            if (tx_pop_s)     tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            if (rx_push_s)    rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            if (rx_pop_ok_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            tx_count_r <= tx_count_s;
            rx_count_r <= rx_count_s;
            state_r    <= state_s;
            if (tmo_clr_s)      tmo_cnt_r <= {TW{1'b0}};
            else if (tmo_inc_s) tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end

    // Registered outputs; the issued byte is held until the next pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spi_data_r   <= 8'h00;
            spi_write_r  <= 1'b0;
            spi_enable_r <= 1'b0;
            idle_r       <= 1'b1;
            tx_full_r    <= 1'b0;
            rx_empty_r   <= 1'b1;
            err_r        <= 2'b00;
        end else begin
            if (tx_pop_s) begin
                spi_data_r  <= tx_head_s[7:0];
                spi_write_r <= tx_head_s[8];
            end
            spi_enable_r <= (state_s == ST_ISSUE);
            idle_r       <= (state_s == ST_IDLE) && (tx_count_s == CNT_ZERO);
            tx_full_r    <= (tx_count_s == FULL_COUNT);
            rx_empty_r   <= (rx_count_s == CNT_ZERO);
            err_r        <= err_s;
        end
    end

    assign tx_full_o    = tx_full_r;
    assign tx_count_o   = tx_count_r;
    assign rx_data_o    = rx_mem_r[rx_rd_ptr_r];
    assign rx_empty_o   = rx_empty_r;
    assign rx_count_o   = rx_count_r;
    assign spi_data_o   = spi_data_r;
    assign spi_write_o  = spi_write_r;
    assign spi_enable_o = spi_enable_r;
    assign idle_o       = idle_r;
    assign err_o        = err_r;
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer: a behavioural SPI master model plus transaction queues
// holding the expected issue order and expected RX bytes.
module tb_spi_txn_sequencer;
    localparam int DEPTH = 8;
    localparam int START_TIMEOUT = 15;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk, rst, tx_push, tx_write, rx_pop, spi_busy, err_clr;
    logic [7:0] tx_data, spi_rdata, rx_data, spi_data;
    logic tx_full, rx_empty, spi_write, spi_enable, idle;
    logic [CW-1:0] tx_count, rx_count;
    logic [1:0] err;

    int vectors = 0;
    int miscompares = 0;
    int enable_count = 0;
    logic [8:0] exp_issue[$];
    logic [7:0] exp_rx[$];
    bit stall_mode = 1'b0;
    bit cfg_random = 1'b0;
    bit fixed_rdata_en = 1'b0;
    logic [7:0] fixed_rdata = 8'h00;
    int cfg_start_dly = 0;
    int cfg_hold = 20;

    spi_txn_sequencer #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .tx_push_i(tx_push), .tx_write_i(tx_write), .tx_data_i(tx_data),
        .tx_full_o(tx_full), .tx_count_o(tx_count),
        .rx_pop_i(rx_pop), .rx_data_o(rx_data), .rx_empty_o(rx_empty), .rx_count_o(rx_count),
        .spi_data_o(spi_data), .spi_write_o(spi_write), .spi_enable_o(spi_enable),
        .spi_busy_i(spi_busy), .spi_data_i(spi_rdata),
        .idle_o(idle), .err_o(err), .err_clr_i(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural master: checks each enable against the expected issue order,
    // runs busy for a while, returns a byte at busy fall.
    initial begin : master_model
        logic [8:0] want;
        logic [7:0] held_data;
        logic held_write;
        bit unstable, aborted;
        int dly, hold;
        spi_busy = 1'b0;
        spi_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && spi_enable === 1'b1) begin
                enable_count++;
                vectors++;
                if (spi_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL issue_overlap: enable while busy=%b, required busy=0", spi_busy);
                end
                vectors++;
                if (exp_issue.size() == 0) begin
                    miscompares++;
                    $display("FAIL issue_unexpected: got w=%b d=%02h, no issue expected", spi_write, spi_data);
                    want = {spi_write, spi_data};
                end else begin
                    want = exp_issue.pop_front();
                    if (spi_write !== want[8] || (want[8] && spi_data !== want[7:0])) begin
                        miscompares++;
                        $display("FAIL issue_order: got w=%b d=%02h, required w=%b d=%02h",
                                 spi_write, spi_data, want[8], want[7:0]);
                    end
                end
                held_data = spi_data;
                held_write = spi_write;
                if (!stall_mode) begin
                    dly = cfg_random ? int'($urandom_range(0, 4)) : cfg_start_dly;
                    hold = cfg_random ? int'($urandom_range(1, 12)) : cfg_hold;
                    aborted = 1'b0;
                    unstable = 1'b0;
                    for (int i = 0; i < dly && !aborted; i++) begin
                        @(negedge clk);
                        aborted = rst;
                    end
                    if (!aborted) spi_busy = 1'b1;
                    for (int i = 0; i < hold && !aborted; i++) begin
                        @(negedge clk);
                        aborted = rst;
                        if (!aborted && (spi_data !== held_data || spi_write !== held_write || spi_enable !== 1'b0))
                            unstable = 1'b1;
                    end
                    spi_busy = 1'b0;
                    if (!aborted) begin
                        spi_rdata = fixed_rdata_en ? fixed_rdata : 8'($urandom);
                        if (!want[8]) exp_rx.push_back(spi_rdata);
                        vectors++;
                        if (unstable) begin
                            miscompares++;
                            $display("FAIL issue_stable: spi outputs changed or enable repeated during busy, required w=%b d=%02h held",
                                     held_write, held_data);
                        end
                    end
                end
            end
        end
    end

    task automatic push_req(input logic wr, input logic [7:0] d, input bit accepted);
        tx_push = 1'b1;
        tx_write = wr;
        tx_data = d;
        if (accepted) exp_issue.push_back({wr, d});
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    task automatic pop_drive();
        rx_pop = 1'b1;
        void'(exp_rx.pop_front());
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle === 1'b1 && exp_issue.size() == 0 && spi_busy === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (n < budget);
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_push = 1'b0; tx_write = 1'b0; tx_data = 8'h00;
        rx_pop = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors += 9;
        if (spi_data !== 8'h00) begin miscompares++; $display("FAIL reset_spi_data: got %02h required 00", spi_data); end
        if (spi_write !== 1'b0) begin miscompares++; $display("FAIL reset_spi_write: got %b required 0", spi_write); end
        if (spi_enable !== 1'b0) begin miscompares++; $display("FAIL reset_spi_enable: got %b required 0", spi_enable); end
        if (err !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b required 00", err); end
        if (tx_full !== 1'b0) begin miscompares++; $display("FAIL reset_tx_full: got %b required 0", tx_full); end
        if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_rx_empty: got %b required 1", rx_empty); end
        if (tx_count !== 4'd0) begin miscompares++; $display("FAIL reset_tx_count: got %0d required 0", tx_count); end
        if (rx_count !== 4'd0) begin miscompares++; $display("FAIL reset_rx_count: got %0d required 0", rx_count); end
        if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b required 1", idle); end
    endtask

    task automatic test_single_write();
        bit ok;
        cfg_random = 1'b0; cfg_start_dly = 0; cfg_hold = 20;
        enable_count = 0;
        push_req(1'b1, 8'hA5, 1'b1);
        wait_idle(80, ok);
        vectors += 5;
        if (!ok) begin miscompares++; $display("FAIL write_idle: no return to idle, %0d issues pending", exp_issue.size()); end
        if (enable_count != 1) begin miscompares++; $display("FAIL write_enables: got %0d pulses required 1", enable_count); end
        if (spi_data !== 8'hA5 || spi_write !== 1'b1) begin
            miscompares++; $display("FAIL write_hold: got w=%b d=%02h required w=1 d=a5", spi_write, spi_data);
        end
        if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL write_rx_empty: got %b required 1", rx_empty); end
        if (rx_count !== 4'd0) begin miscompares++; $display("FAIL write_rx_count: got %0d required 0", rx_count); end
    endtask

    task automatic test_single_read();
        bit ok;
        fixed_rdata_en = 1'b1; fixed_rdata = 8'h3C;
        push_req(1'b0, 8'h00, 1'b1);
        wait_idle(80, ok);
        fixed_rdata_en = 1'b0;
        vectors += 4;
        if (!ok) begin miscompares++; $display("FAIL read_idle: no return to idle"); end
        if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL read_data: got %02h required 3c", rx_data); end
        if (rx_count !== 4'd1) begin miscompares++; $display("FAIL read_count: got %0d required 1", rx_count); end
        if (rx_empty !== 1'b0) begin miscompares++; $display("FAIL read_not_empty: got %b required 0", rx_empty); end
        pop_drive();
        vectors += 2;
        if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL read_pop_empty: got %b required 1", rx_empty); end
        if (rx_count !== 4'd0) begin miscompares++; $display("FAIL read_pop_count: got %0d required 0", rx_count); end
        // Pop while empty must be ignored
        pop_drive();
        vectors++;
        if (rx_count !== 4'd0 || rx_empty !== 1'b1) begin
            miscompares++; $display("FAIL read_pop_underflow: got count=%0d empty=%b required 0/1", rx_count, rx_empty);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        cfg_hold = 6;
        enable_count = 0;
        push_req(1'b1, 8'h11, 1'b1);
        push_req(1'b0, 8'($urandom), 1'b1);
        push_req(1'b1, 8'h22, 1'b1);
        wait_idle(150, ok);
        vectors += 4;
        if (!ok) begin miscompares++; $display("FAIL b2b_idle: no return to idle"); end
        if (enable_count != 3) begin miscompares++; $display("FAIL b2b_enables: got %0d required 3", enable_count); end
        if (rx_count !== 4'd1) begin miscompares++; $display("FAIL b2b_rx_count: got %0d required 1", rx_count); end
        if (exp_rx.size() != 1 || rx_data !== exp_rx[0]) begin
            miscompares++; $display("FAIL b2b_rx_data: got %02h, model holds %0d bytes", rx_data, exp_rx.size());
        end
        pop_drive();
    endtask

    task automatic test_rx_full();
        bit ok;
        logic [7:0] want;
        cfg_hold = 3;
        enable_count = 0;
        for (int i = 0; i < DEPTH + 1; i++) push_req(1'b0, 8'($urandom), 1'b1);
        repeat (150) @(negedge clk);
        vectors += 4;
        if (rx_count !== 4'(DEPTH)) begin miscompares++; $display("FAIL rxfull_count: got %0d required %0d", rx_count, DEPTH); end
        if (tx_count !== 4'd1) begin miscompares++; $display("FAIL rxfull_tx_count: got %0d required 1", tx_count); end
        if (enable_count != DEPTH) begin miscompares++; $display("FAIL rxfull_enables: got %0d required %0d", enable_count, DEPTH); end
        if (idle !== 1'b0) begin miscompares++; $display("FAIL rxfull_idle: got %b required 0", idle); end
        want = exp_rx[0];
        vectors++;
        if (rx_data !== want) begin miscompares++; $display("FAIL rxfull_head: got %02h required %02h", rx_data, want); end
        pop_drive();
        wait_idle(80, ok);
        vectors += 3;
        if (!ok) begin miscompares++; $display("FAIL rxfull_resume: ninth read not issued"); end
        if (enable_count != DEPTH + 1) begin miscompares++; $display("FAIL rxfull_enables2: got %0d required %0d", enable_count, DEPTH + 1); end
        if (rx_count !== 4'(DEPTH)) begin miscompares++; $display("FAIL rxfull_count2: got %0d required %0d", rx_count, DEPTH); end
        while (exp_rx.size() > 0) begin
            want = exp_rx[0];
            vectors++;
            if (rx_data !== want || rx_empty !== 1'b0) begin
                miscompares++; $display("FAIL rxfull_drain: got %02h empty=%b required %02h", rx_data, rx_empty, want);
            end
            pop_drive();
        end
    endtask

    task automatic test_stall_errors();
        bit ok;
        int n;
        stall_mode = 1'b1;
        push_req(1'b1, 8'($urandom), 1'b1);
        n = 0;
        while (spi_enable !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        repeat (START_TIMEOUT) @(negedge clk);
        vectors += 3;
        if (n >= 10) begin miscompares++; $display("FAIL stall_issue: no enable within 10 cycles"); end
        if (err !== 2'b00) begin miscompares++; $display("FAIL stall_tmo_early: got err=%b required 00", err); end
        @(negedge clk);
        if (err !== 2'b10) begin miscompares++; $display("FAIL stall_tmo_set: got err=%b required 10", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 2'b00) begin miscompares++; $display("FAIL stall_clr1: got err=%b required 00", err); end
        // One entry in flight plus DEPTH queued, then one dropped
        enable_count = 0;
        for (int i = 0; i < DEPTH + 2; i++) push_req(1'b1, 8'($urandom), i < DEPTH + 1);
        vectors += 3;
        if (err[0] !== 1'b1) begin miscompares++; $display("FAIL stall_ovf: got err0=%b required 1", err[0]); end
        if (tx_count !== 4'(DEPTH)) begin miscompares++; $display("FAIL stall_tx_count: got %0d required %0d", tx_count, DEPTH); end
        if (tx_full !== 1'b1) begin miscompares++; $display("FAIL stall_tx_full: got %b required 1", tx_full); end
        err_clr = 1'b1;
        push_req(1'b1, 8'hEE, 1'b0);
        err_clr = 1'b0;
        vectors++;
        if (err[0] !== 1'b1) begin miscompares++; $display("FAIL stall_ovf_wins: got err0=%b required 1", err[0]); end
        wait_idle((DEPTH + 1) * (START_TIMEOUT + 6) + 20, ok);
        vectors += 3;
        if (!ok) begin miscompares++; $display("FAIL stall_drain: %0d issues still pending", exp_issue.size()); end
        if (enable_count != DEPTH + 1) begin miscompares++; $display("FAIL stall_enables: got %0d required %0d", enable_count, DEPTH + 1); end
        if (err !== 2'b11) begin miscompares++; $display("FAIL stall_err_both: got err=%b required 11", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 2'b00) begin miscompares++; $display("FAIL stall_clr2: got err=%b required 00", err); end
        stall_mode = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [7:0] want;
        cfg_random = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (exp_issue.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                tx_push = 1'b1;
                tx_write = 1'($urandom);
                tx_data = 8'($urandom);
                exp_issue.push_back({tx_write, tx_data});
            end
            if (rx_empty === 1'b0 && $urandom_range(0, 2) == 0) begin
                want = exp_rx.size() > 0 ? exp_rx[0] : ~rx_data;
                vectors++;
                if (rx_data !== want) begin miscompares++; $display("FAIL rand_rx: got %02h required %02h", rx_data, want); end
                rx_pop = 1'b1;
                void'(exp_rx.pop_front());
            end
            @(negedge clk);
            tx_push = 1'b0;
            rx_pop = 1'b0;
        end
        n = 0;
        while (!(idle === 1'b1 && exp_issue.size() == 0 && spi_busy === 1'b0) && n < 2000) begin
            if (rx_empty === 1'b0) begin
                want = exp_rx.size() > 0 ? exp_rx[0] : ~rx_data;
                vectors++;
                if (rx_data !== want) begin miscompares++; $display("FAIL rand_rx_drain: got %02h required %02h", rx_data, want); end
                pop_drive();
            end else begin
                @(negedge clk);
            end
            n++;
        end
        wait_idle(20, ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL rand_idle: %0d issues pending", exp_issue.size()); end
        if (rx_count !== 4'(exp_rx.size())) begin miscompares++; $display("FAIL rand_rx_count: got %0d required %0d", rx_count, exp_rx.size()); end
        while (exp_rx.size() > 0) begin
            want = exp_rx[0];
            vectors++;
            if (rx_data !== want) begin miscompares++; $display("FAIL rand_rx_tail: got %02h required %02h", rx_data, want); end
            pop_drive();
        end
        vectors += 2;
        if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL rand_rx_empty: got %b required 1", rx_empty); end
        if (err !== 2'b00) begin miscompares++; $display("FAIL rand_err: got %b required 00", err); end
        cfg_random = 1'b0;
    endtask

    task automatic test_reset_midread();
        int n, en_before;
        cfg_start_dly = 0; cfg_hold = 20;
        push_req(1'b0, 8'h00, 1'b1);
        push_req(1'b1, 8'h5A, 1'b1);
        n = 0;
        while (spi_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors += 10;
        if (n >= 20) begin miscompares++; $display("FAIL rstmid_busy: read never started"); end
        if (spi_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_spi_data: got %02h required 00", spi_data); end
        if (spi_write !== 1'b0) begin miscompares++; $display("FAIL rstmid_spi_write: got %b required 0", spi_write); end
        if (spi_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_spi_enable: got %b required 0", spi_enable); end
        if (err !== 2'b00) begin miscompares++; $display("FAIL rstmid_err: got %b required 00", err); end
        if (tx_full !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_full: got %b required 0", tx_full); end
        if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_rx_empty: got %b required 1", rx_empty); end
        if (tx_count !== 4'd0) begin miscompares++; $display("FAIL rstmid_tx_count: got %0d required 0", tx_count); end
        if (rx_count !== 4'd0) begin miscompares++; $display("FAIL rstmid_rx_count: got %0d required 0", rx_count); end
        if (idle !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle: got %b required 1", idle); end
        exp_issue.delete();
        exp_rx.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en_before = enable_count;
        repeat (30) @(negedge clk);
        vectors += 3;
        if (rx_empty !== 1'b1 || rx_count !== 4'd0) begin
            miscompares++; $display("FAIL rstmid_no_push: got empty=%b count=%0d required 1/0", rx_empty, rx_count);
        end
        if (enable_count != en_before) begin miscompares++; $display("FAIL rstmid_no_issue: got %0d new enables required 0", enable_count - en_before); end
        if (idle !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle_after: got %b required 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_rx_full();
        test_stall_errors();
        test_random();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
